// File: rtl/vco_freq_lock_ctrl.sv
// ============================================================================
// Module   : vco_freq_lock_ctrl
// Purpose  : Frequency-lock controller. It counts feedback ticks per window,
//            binary-searches the vco code, then tracks it in +/-1 steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vco_freq_lock_ctrl #(
    parameter int RESOLUTION_BITS = 8,
    parameter int COUNT_BITS      = 16,
    parameter int WINDOW_CYCLES   = 1024,
    parameter int TOLERANCE       = 2,
    parameter int LOCK_WINDOWS    = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       en_i,
    input  logic [COUNT_BITS-1:0]      target_count_i,
    input  logic                       fb_tick_i,
    output logic [RESOLUTION_BITS-1:0] voltage_ctrl_o,
    output logic [COUNT_BITS-1:0]      measured_count_o,
    output logic                       measure_valid_o,
    output logic                       lock_o
);

    localparam int c_win_w  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int c_bit_w  = (RESOLUTION_BITS > 1) ? $clog2(RESOLUTION_BITS) : 1;
    localparam int c_good_w = $clog2(LOCK_WINDOWS + 1);

    localparam logic [c_win_w-1:0]         c_win_last = c_win_w'(WINDOW_CYCLES - 1);
    localparam logic [COUNT_BITS-1:0]      c_cnt_max  = '1;
    localparam logic [RESOLUTION_BITS-1:0] c_code_max = '1;
    localparam logic [RESOLUTION_BITS-1:0] c_code_mid = {1'b1, {(RESOLUTION_BITS-1){1'b0}}};
    localparam logic [c_bit_w-1:0]         c_bit_top  = c_bit_w'(RESOLUTION_BITS - 1);
    localparam logic [c_good_w-1:0]        c_good_max = c_good_w'(LOCK_WINDOWS);
    localparam logic signed [COUNT_BITS:0] c_tol      = (COUNT_BITS+1)'(TOLERANCE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRACK  = 2'd2
    } state_t;

    state_t                       r_state, w_state;
    logic [RESOLUTION_BITS-1:0]   r_code, w_code;
    logic [COUNT_BITS-1:0]        r_meas, w_meas;
    logic                         r_valid, w_valid;
    logic                         r_lock, w_lock;
    logic [c_win_w-1:0]           r_win, w_win;
    logic [COUNT_BITS-1:0]        r_ticks, w_ticks;
    logic [c_bit_w-1:0]           r_bit, w_bit;
    logic [c_good_w-1:0]          r_good, w_good;

    logic [COUNT_BITS-1:0]        w_ticks_inc;
    logic                         w_last;
    logic signed [COUNT_BITS:0]   w_err;

    // The tick arriving in the last window cycle still belongs to this window.
    assign w_ticks_inc = (r_ticks == c_cnt_max) ? r_ticks : r_ticks + COUNT_BITS'(fb_tick_i);
    assign w_last      = (r_win == c_win_last);
    assign w_err       = $signed({1'b0, w_ticks_inc}) - $signed({1'b0, target_count_i});

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_comb begin
        w_state = r_state;
        w_code  = r_code;
        w_meas  = r_meas;
        w_valid = 1'b0;
        w_lock  = r_lock;
        w_win   = r_win;
        w_ticks = r_ticks;
        w_bit   = r_bit;
        w_good  = r_good;

        if (!en_i) begin
            // Partial window is abandoned; code and last measurement hold.
            w_state = ST_IDLE;
            w_lock  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state = ST_SEARCH;
                    w_code  = c_code_mid;
                    w_bit   = c_bit_top;
                    w_win   = '0;
                    w_ticks = '0;
                    w_good  = '0;
                    w_lock  = 1'b0;
                end
                ST_SEARCH, ST_TRACK: begin
                    if (w_last) begin
                        w_meas  = w_ticks_inc;
                        w_valid = 1'b1;
                        w_win   = '0;
                        w_ticks = '0;
                        if (r_state == ST_SEARCH) begin
                            if (w_ticks_inc >= target_count_i) begin
                                w_code[r_bit] = 1'b0;
                            end
                            if (r_bit != '0) begin
                                w_bit         = r_bit - c_bit_w'(1);
                                w_code[w_bit] = 1'b1;
                            end else begin
                                w_state = ST_TRACK;
                            end
                        end else if (w_err > c_tol) begin
                            w_code = (r_code != '0) ? r_code - RESOLUTION_BITS'(1) : r_code;
                            w_good = '0;
                            w_lock = 1'b0;
                        end else if (w_err < -c_tol) begin
                            w_code = (r_code != c_code_max) ? r_code + RESOLUTION_BITS'(1) : r_code;
                            w_good = '0;
                            w_lock = 1'b0;
                        end else begin
                            w_good = (r_good == c_good_max) ? r_good : r_good + c_good_w'(1);
                            w_lock = (w_good == c_good_max);
                        end
                    end else begin
                        w_win   = r_win + c_win_w'(1);
                        w_ticks = w_ticks_inc;
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                    w_lock  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_code  <= '0;
            r_meas  <= '0;
            r_valid <= 1'b0;
            r_lock  <= 1'b0;
            r_win   <= '0;
            r_ticks <= '0;
            r_bit   <= '0;
            r_good  <= '0;
        end else begin
            r_code  <= w_code;
            r_meas  <= w_meas;
            r_valid <= w_valid;
            r_lock  <= w_lock;
            r_win   <= w_win;
            r_ticks <= w_ticks;
            r_bit   <= w_bit;
            r_good  <= w_good;
        end
    end

    assign voltage_ctrl_o   = r_code;
    assign measured_count_o = r_meas;
    assign measure_valid_o  = r_valid;
    assign lock_o           = r_lock;

endmodule

`default_nettype wire
